// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: expands the key schedule, then runs one
// round per clock and registers the plaintext with a completion flag.
module aes_decryption (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic [127:0] outputData,
  output logic         dataDecryptedFlag
);

  localparam int unsigned BlockWidth   = 128;
  localparam int unsigned CountWidth   = 4;
  localparam int unsigned NumRoundKeys = 11;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KEYEXP = 3'd1;
  localparam logic [2:0] INIT   = 3'd2;
  localparam logic [2:0] ROUNDS = 3'd3;
  localparam logic [2:0] FINAL  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]            fsmState;
  logic [2:0]            nextState;
  logic [BlockWidth-1:0] stateReg;
  logic [CountWidth-1:0] roundCount;
  logic [BlockWidth-1:0] roundKeys [NumRoundKeys];

  logic [BlockWidth-1:0] invRowsSub;
  logic [BlockWidth-1:0] roundOut;
  logic [BlockWidth-1:0] finalOut;
  logic [BlockWidth-1:0] nextKey;
  logic [CountWidth-1:0] keyWriteIdx;

  // GF(2^8) arithmetic over x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gfMul(gfMul(r, r), a);
    return gfMul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gfInv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return gfInv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; k = row + 4*col.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = invSbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      o[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      o[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      o[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rconFor(input logic [CountWidth-1:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expandKey(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;
    t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])};
    w0 = prev[127:96] ^ t ^ {rcon, 24'h000000};
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign invRowsSub  = invSubBytes(invShiftRows(stateReg));
  assign roundOut    = invMixColumns(invRowsSub ^ roundKeys[roundCount]);
  assign finalOut    = invRowsSub ^ roundKeys[0];
  assign nextKey     = expandKey(roundKeys[roundCount], rconFor(roundCount));
  assign keyWriteIdx = CountWidth'(roundCount + 4'd1);

  always_ff @(posedge clock) begin
    if (resetModule) fsmState <= IDLE;
    else             fsmState <= nextState;
  end

  always_comb begin
    nextState = fsmState;
    case (fsmState)
      IDLE:    if (inputsLoadedFlag) nextState = KEYEXP;
      KEYEXP:  if (roundCount == 4'd9) nextState = INIT;
      INIT:    nextState = ROUNDS;
      ROUNDS:  if (roundCount == 4'd1) nextState = FINAL;
      FINAL:   nextState = DONE;
      DONE:    if (!inputsLoadedFlag) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Block state, round counter and registered outputs
  always_ff @(posedge clock) begin
    if (resetModule) begin
      outputData        <= '0;
      dataDecryptedFlag <= 1'b0;
      stateReg          <= '0;
      roundCount        <= '0;
    end else begin
      case (fsmState)
        IDLE: begin
          if (inputsLoadedFlag) begin
            stateReg   <= inputData;
            roundCount <= '0;
          end
        end
        KEYEXP: roundCount <= keyWriteIdx;
        INIT: begin
          stateReg   <= stateReg ^ roundKeys[10];
          roundCount <= 4'd9;
        end
        ROUNDS: begin
          stateReg   <= roundOut;
          roundCount <= CountWidth'(roundCount - 4'd1);
        end
        FINAL: begin
          outputData        <= finalOut;
          dataDecryptedFlag <= 1'b1;
        end
        DONE: if (!inputsLoadedFlag) dataDecryptedFlag <= 1'b0;
        default: ;
      endcase
    end
  end

  // Round key storage; contents are only meaningful after a completed KEYEXP
  always_ff @(posedge clock) begin
    if (!resetModule) begin
      if (fsmState == IDLE && inputsLoadedFlag) roundKeys[0] <= key;
      else if (fsmState == KEYEXP)              roundKeys[keyWriteIdx] <= nextKey;
    end
  end

endmodule

// File: tb/tb_aes_decryption.sv
// Randomized and known-answer bench for aes_decryption against a table-driven
// AES-128 inverse-cipher model.
module tb_aes_decryption;

  logic         clock = 1'b0;
  logic         resetModule;
  logic [127:0] inputData;
  logic [127:0] key;
  logic         inputsLoadedFlag;
  logic [127:0] outputData;
  logic         dataDecryptedFlag;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] sboxT    [256];
  logic [7:0] invSboxT [256];

  always #5 clock = ~clock;

  aes_decryption dut (
    .clock             (clock),
    .resetModule       (resetModule),
    .inputData         (inputData),
    .key               (key),
    .inputsLoadedFlag  (inputsLoadedFlag),
    .outputData        (outputData),
    .dataDecryptedFlag (dataDecryptedFlag)
  );

  task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] mulRef(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
    x = a; y = b; p = 8'h00;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = (x[7]) ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box built by brute-force inverse search, inverse S-box by table inversion.
  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && mulRef(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sboxT[x]    = s;
      invSboxT[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] refDecrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s   [4][4];
    logic [7:0]   tmp [4][4];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = mulRef(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = ct[127-8*(r+4*c) -: 8] ^ w[40+c][31-8*r -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r][c] = s[r][(c-r+4)%4];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = invSboxT[tmp[r][c]] ^ w[4*rnd+c][31-8*r -: 8];
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) tmp[r][c] = s[r][c];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = mulRef(tmp[r][c], 8'h0e) ^ mulRef(tmp[(r+1)%4][c], 8'h0b)
                    ^ mulRef(tmp[(r+2)%4][c], 8'h0d) ^ mulRef(tmp[(r+3)%4][c], 8'h09);
      end
    end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic startOp(input logic [127:0] d, input logic [127:0] k);
    inputData        = d;
    key              = k;
    inputsLoadedFlag = 1'b1;
  endtask

  // Called just after an edge; the next edge is the start edge (edge 0).
  task automatic waitResult(input string tag, input logic [127:0] expected, input logic [127:0] prevOut,
                            input int changeAt, input int dropAt);
    int   lat;
    logic heldOk;
    lat    = -1;
    heldOk = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (dataDecryptedFlag) begin
        lat = n;
        break;
      end
      if (outputData !== prevOut) heldOk = 1'b0;
      if (n == changeAt) begin
        inputData = {$urandom, $urandom, $urandom, $urandom};
        key       = {$urandom, $urandom, $urandom, $urandom};
      end
      if (n == dropAt) inputsLoadedFlag = 1'b0;
    end
    checkValue({tag, "_latency"}, 128'(lat), 128'd21);
    checkValue({tag, "_heldOutput"}, 128'(heldOk), 128'd1);
    checkValue({tag, "_plaintext"}, outputData, expected);
  endtask

  task automatic releaseFlag(input string tag, input logic [127:0] expected);
    inputsLoadedFlag = 1'b0;
    @(posedge clock); #1;
    checkValue({tag, "_flagDrop"}, 128'(dataDecryptedFlag), 128'd0);
    checkValue({tag, "_outKept"}, outputData, expected);
  endtask

  initial begin : stimulus
    logic [127:0] c1Key, c1Ct, c1Pt, bKey, bCt, bPt, zCt;
    logic [127:0] d, k, exp, prev;
    logic         stable;

    c1Key = 128'h000102030405060708090a0b0c0d0e0f;
    c1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    c1Pt  = 128'h00112233445566778899aabbccddeeff;
    bKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bCt   = 128'h3925841d02dc09fbdc118597196a0b32;
    bPt   = 128'h3243f6a8885a308d313198a2e0370734;
    zCt   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    buildTables();
    checkValue("model_c1", refDecrypt(c1Ct, c1Key), c1Pt);

    resetModule      = 1'b1;
    inputsLoadedFlag = 1'b0;
    inputData        = '0;
    key              = '0;
    repeat (3) @(posedge clock);
    #1;
    checkValue("reset_out", outputData, 128'h0);
    checkValue("reset_flag", 128'(dataDecryptedFlag), 128'd0);
    resetModule = 1'b0;

    startOp(c1Ct, c1Key);
    waitResult("c1", c1Pt, 128'h0, -1, -1);
    stable = 1'b1;
    repeat (300) begin
      @(posedge clock); #1;
      if (!dataDecryptedFlag || outputData !== c1Pt) stable = 1'b0;
    end
    checkValue("c1_hold", 128'(stable), 128'd1);
    releaseFlag("c1", c1Pt);

    startOp(bCt, bKey);
    waitResult("vecB", bPt, c1Pt, -1, -1);
    releaseFlag("vecB", bPt);

    startOp(zCt, 128'h0);
    waitResult("zeroKey", 128'h0, bPt, -1, -1);
    releaseFlag("zeroKey", 128'h0);

    d   = {$urandom, $urandom, $urandom, $urandom};
    k   = {$urandom, $urandom, $urandom, $urandom};
    exp = refDecrypt(d, k);
    startOp(d, k);
    waitResult("midChange", exp, 128'h0, 4, -1);
    releaseFlag("midChange", exp);
    prev = exp;

    d   = {$urandom, $urandom, $urandom, $urandom};
    k   = {$urandom, $urandom, $urandom, $urandom};
    exp = refDecrypt(d, k);
    startOp(d, k);
    waitResult("earlyDrop", exp, prev, -1, 3);
    releaseFlag("earlyDrop", exp);
    prev = exp;

    // Reset sampled on edge 10 of an operation, flag left high throughout.
    d   = {$urandom, $urandom, $urandom, $urandom};
    k   = {$urandom, $urandom, $urandom, $urandom};
    exp = refDecrypt(d, k);
    startOp(d, k);
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clock); #1;
      if (dataDecryptedFlag || outputData !== prev) stable = 1'b0;
    end
    checkValue("preReset_quiet", 128'(stable), 128'd1);
    resetModule = 1'b1;
    @(posedge clock); #1;
    checkValue("midReset_out", outputData, 128'h0);
    checkValue("midReset_flag", 128'(dataDecryptedFlag), 128'd0);
    resetModule = 1'b0;
    waitResult("postReset", exp, 128'h0, -1, -1);
    releaseFlag("postReset", exp);
    prev = exp;

    for (int i = 0; i < 6; i++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      k   = {$urandom, $urandom, $urandom, $urandom};
      exp = refDecrypt(d, k);
      startOp(d, k);
      waitResult($sformatf("rand%0d", i), exp, prev, -1, -1);
      releaseFlag($sformatf("rand%0d", i), exp);
      prev = exp;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
